// File: rtl/eb_ctrl_pkg.sv
// eb_ctrl_pkg: shared widths, gains and saturation helpers for the current loop.
package eb_ctrl_pkg;
  localparam int ERR_W = 10;
  localparam int INTEG_W = 17;
  localparam int I_SHIFT = 4;
  localparam int D_GAIN_SHIFT = 2;
  localparam int DEC_FULL = 20;
  localparam int DEC_FAST = 9;
  localparam int D_W = 9;
  localparam int SUM_W = 15;
  localparam int HIST_D = 3;
  localparam logic [11:0] MAG_MAX = 12'hFFF;
  function automatic logic signed [ERR_W-1:0] sat_err(input logic signed [12:0] x);
    return (x > 13'sd511) ? 10'sd511 : (x < -13'sd512) ? 10'sh200 : x[ERR_W-1:0];
  endfunction
  function automatic logic signed [D_W-1:0] sat_d(input logic signed [10:0] x);
    return (x > 11'sd255) ? 9'sd255 : (x < -11'sd256) ? 9'sh100 : x[D_W-1:0];
  endfunction
endpackage

// File: rtl/err_hist_q.sv
// err_hist_q: shift queue of past error samples; dout_old is the oldest entry.
module err_hist_q
  import eb_ctrl_pkg::*;
#(
  parameter int W = ERR_W,
  parameter int D = HIST_D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                shift,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] dout_old
);
  logic [D-1:0][W-1:0] r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else if (clr) r_q <= '0;
    else if (shift) r_q <= {r_q[D-2:0], din};
  assign dout_old = r_q[D-1];
endmodule

// File: rtl/pid_curr_ctrl.sv
// pid_curr_ctrl: decimated PID motor-current loop producing a 12-bit PWM drive magnitude.
module pid_curr_ctrl
  import eb_ctrl_pkg::*;
#(
  parameter bit FAST_SIM = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] target_curr,
  input  logic [11:0] avg_curr,
  input  logic        cur_valid,
  input  logic        not_pedaling,
  output logic [11:0] drv_mag,
  output logic        drv_valid
);
  localparam int DEC_W = FAST_SIM ? DEC_FAST : DEC_FULL;
  logic [DEC_W-1:0] r_cnt;
  logic signed [ERR_W-1:0] r_err;
  logic signed [ERR_W-1:0] w_hist_old;
  logic [INTEG_W-1:0] r_integ;
  logic r_v1;
  logic r_np;
  logic w_tick;
  logic signed [12:0] w_diff;
  logic signed [INTEG_W+1:0] w_integ_nx;
  logic [INTEG_W-1:0] w_integ_clamp;
  logic signed [D_W-1:0] w_d;
  logic [12:0] w_i_term;
  logic signed [SUM_W-1:0] w_sum;
  logic [11:0] w_mag;
  assign w_tick = &r_cnt;
  assign w_diff = $signed({1'b0, target_curr}) - $signed({1'b0, avg_curr});
  assign w_integ_nx = $signed({2'b00, r_integ}) + (INTEG_W+2)'(r_err);
  // sign bit means underflow, bit INTEG_W means overflow past the 17-bit ceiling
  assign w_integ_clamp = w_integ_nx[INTEG_W+1] ? '0 : w_integ_nx[INTEG_W] ? '1 : w_integ_nx[INTEG_W-1:0];
  assign w_d = sat_d(11'(r_err) - 11'(w_hist_old));
  assign w_i_term = 13'(r_integ >> I_SHIFT);
  assign w_sum = SUM_W'(r_err) + $signed({2'b00, w_i_term}) + (SUM_W'(w_d) <<< D_GAIN_SHIFT);
  assign w_mag = w_sum[SUM_W-1] ? '0 : (w_sum > 15'sd4095) ? MAG_MAX : w_sum[11:0];
  err_hist_q u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (not_pedaling),
    .shift   (w_tick),
    .din     (r_err),
    .dout_old(w_hist_old)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt     <= '0;
      r_err     <= '0;
      r_integ   <= '0;
      r_v1      <= 1'b0;
      r_np      <= 1'b0;
      drv_mag   <= '0;
      drv_valid <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
      r_v1      <= cur_valid;
      drv_valid <= r_v1;
      r_np      <= not_pedaling;
      if (not_pedaling) begin
        r_err   <= '0;
        r_integ <= '0;
      end else begin
        if (cur_valid) r_err <= sat_err(w_diff);
        if (w_tick) r_integ <= w_integ_clamp;
      end
      if (r_np) drv_mag <= '0;
      else if (r_v1) drv_mag <= w_mag;
    end
endmodule
